// File: rtl/wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wptr_full_ctrl
// Purpose  : Write-domain pointer and status controller for a dual-clock FIFO.
//            Keeps the binary/Gray write pointers and synchronises the Gray
//            read pointer into wclk. Produces registered full, almost-full
//            and fill-level outputs, plus a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module wptr_full_ctrl #(
  parameter int ASIZE       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wclk,
  input  logic             rst,
  input  logic             winc,
  input  logic [ASIZE:0]   rptr_gray,
  input  logic [ASIZE:0]   afull_thresh,
  input  logic             clr_ovf,
  output logic [ASIZE:0]   wptr,
  output logic [ASIZE-1:0] waddr,
  output logic             wfull,
  output logic             walmost_full,
  output logic [ASIZE:0]   wlevel,
  output logic             wovf
);

  // Synchroniser chain; the newest sample enters at bit-slice 0.
  logic [SYNC_STAGES-1:0][ASIZE:0] r_sync;
  logic [ASIZE:0]                  w_wq_rptr;

  logic [ASIZE:0] r_wbin;
  logic [ASIZE:0] r_wptr;
  logic           r_wfull;
  logic           r_walmost_full;
  logic [ASIZE:0] r_wlevel;
  logic           r_wovf;

  logic           w_accept;
  logic [ASIZE:0] w_wbinnext;
  logic [ASIZE:0] w_wgraynext;
  logic [ASIZE:0] w_rbin_sync;
  logic [ASIZE:0] w_diff;
  logic [ASIZE:0] w_full_match;

  assign w_wq_rptr = r_sync[SYNC_STAGES-1];

  // Shift the asynchronous Gray read pointer through the flop chain
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rptr_gray};
    end
  end

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
  genvar gi;
  generate
    for (gi = 0; gi <= ASIZE; gi++) begin : g_gray2bin
      assign w_rbin_sync[gi] = ^w_wq_rptr[ASIZE:gi];
    end
  endgenerate

  assign w_accept     = winc & ~r_wfull;
  assign w_wbinnext   = r_wbin + {{ASIZE{1'b0}}, w_accept};
  assign w_wgraynext  = w_wbinnext ^ (w_wbinnext >> 1);
  assign w_diff       = w_wbinnext - w_rbin_sync;
  // Full when the write pointer is exactly one lap ahead of the read pointer:
  // in Gray code that means the top two bits differ and the rest match.
  assign w_full_match = {~w_wq_rptr[ASIZE:ASIZE-1], w_wq_rptr[ASIZE-2:0]};

  // Advance the write pointers and register the derived status flags
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      r_wbin         <= '0;
      r_wptr         <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_wlevel       <= '0;
    end else begin
      r_wbin         <= w_wbinnext;
      r_wptr         <= w_wgraynext;
      r_wfull        <= (w_wgraynext == w_full_match);
      r_walmost_full <= (w_diff >= afull_thresh);
      r_wlevel       <= w_diff;
    end
  end

  // Sticky overflow: a write attempt while full wins over a same-edge clear
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      r_wovf <= 1'b0;
    end else if (winc && r_wfull) begin
      r_wovf <= 1'b1;
    end else if (clr_ovf) begin
      r_wovf <= 1'b0;
    end
  end

  assign wptr         = r_wptr;
  assign waddr        = r_wbin[ASIZE-1:0];
  assign wfull        = r_wfull;
  assign walmost_full = r_walmost_full;
  assign wlevel       = r_wlevel;
  assign wovf         = r_wovf;

endmodule
`default_nettype wire
